uart_cmd_parser: RTL
====================

# uart_cmd_parser

Packet decoder directly downstream of the UART receiver: consumes the received byte stream, frames 5-byte command packets, performs writes/reads on the debugger's probe register file, and emits ACK/NAK/read-data response bytes toward the UART transmitter. It turns raw RX bytes into register-level debug transactions.

## Interface

Parameters
- SYNC_BYTE, 8'hA5, packet start marker
- NUM_REGS, 16, number of addressable probe registers (addresses 0..NUM_REGS-1)
- TIMEOUT_CYCLES, 1200000, max iCE_CLK cycles between bytes of one packet (100 ms at 12 MHz)

Ports
- iCE_CLK  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- rx_byte  in  8  byte from receiver
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- reg_wr_en  out  1  one-cycle register write strobe
- reg_addr  out  8  register address (write and read)
- reg_wdata  out  8  write data
- reg_rdata  in  8  read data for reg_addr, combinational, valid same cycle
- tx_byte  out  8  response byte to transmitter
- tx_valid  out  1  response byte valid
- tx_ready  in  1  transmitter accepts tx_byte
- busy  out  1  high in EXEC/SEND0/SEND1; rx bytes dropped
- err_count  out  8  saturating error counter

## Operation

- Packet: SYNC_BYTE, CMD, ADDR, DATA, CSUM; CSUM = CMD ^ ADDR ^ DATA.
- CMD 8'h57 ('W'): write DATA to ADDR; response 8'h06.
- CMD 8'h52 ('R'): DATA ignored (still in checksum); response 8'h06 then reg_rdata.
- Error (bad CSUM, unknown CMD, ADDR >= NUM_REGS): no register access; response 8'h15; err_count += 1, saturating at 255.
- States: IDLE -> GET_CMD -> GET_ADDR -> GET_DATA -> GET_CSUM -> EXEC -> SEND0 -> (SEND1 on good read) -> IDLE. GET_* advance on rx_valid, capturing the byte.
- IDLE: non-SYNC bytes discarded silently. SYNC received in GET_* states is treated as ordinary data.
- Bytes with rx_valid while busy are dropped; no error counted.
- Inter-byte timeout (when compiled in): counter cleared on each rx_valid in GET_* states; at TIMEOUT_CYCLES -> IDLE, err_count += 1, no response.

## Timing

- Reset values: reg_wr_en 0, reg_addr 0, reg_wdata 0, tx_byte 0, tx_valid 0, busy 0, err_count 0; state IDLE; timer 0.
- CSUM accepted on cycle N -> EXEC on N+1: reg_wr_en pulses exactly that cycle (good write); reg_rdata captured that cycle (good read).
- tx_valid rises on N+2 (SEND0); tx_byte stable while tx_valid && !tx_ready. Transfer = tx_valid && tx_ready on a rising edge.
- Read: SEND0 transfer -> SEND1 next cycle, tx_valid stays high, tx_byte = captured rdata; SEND1 transfer -> IDLE, tx_valid 0 next cycle.
- Minimum turnaround: IDLE reached 1 cycle after final transfer; new SYNC accepted from that cycle.
- rst mid-packet or mid-send: abandons everything, outputs to reset values next cycle; partially sent responses not resumed.
- err_count increment and timeout in same cycle cannot occur (timeout only in GET_*).

## Configuration

- CMD_PARSER_TIMEOUT_EN defined: timeout counter and TIMEOUT_CYCLES behaviour present.
- Undefined: no counter; GET_* states wait indefinitely; TIMEOUT_CYCLES ignored.

## Structure

- Package uart_dbg_pkg: state enum, CMD_WRITE 8'h57, CMD_READ 8'h52, RSP_ACK 8'h06, RSP_NAK 8'h15, default SYNC_BYTE.
- One sub-module: byte_timer (clear, enable, expired pulse; parameterised by TIMEOUT_CYCLES), instantiated only under CMD_PARSER_TIMEOUT_EN.

## Test plan

- Send A5 57 03 5A 0E, tx_ready=1 -> reg_wr_en pulse with addr 03, wdata 5A; tx bytes 06.
- Send A5 52 02 00 50 with reg_rdata=C3 at addr 02 -> no write; tx bytes 06, C3.
- Send A5 57 03 5A 0F -> no write; tx 15; err_count 1. Repeat 300 times -> err_count holds 255.
- Send 00 11 A5 57 20 01 76 (addr 32 >= 16) -> leading bytes ignored, tx 15.
- Hold tx_ready=0 for 20 cycles during read response -> tx_byte/tx_valid stable; extra rx bytes dropped; bytes 06, rdata in order once ready.
- With CMD_PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=100: send A5 57, idle 100 cycles -> IDLE, err_count 1, no tx; assert rst mid-SEND0 -> tx_valid 0 next cycle.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug command path: parser states,
// command/response codes and the default packet start marker.
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CSUM,
    ST_EXEC,
    ST_SEND0,
    ST_SEND1
  } state_e;

  localparam logic [7:0] CMD_WRITE    = 8'h57;
  localparam logic [7:0] CMD_READ     = 8'h52;
  localparam logic [7:0] RSP_ACK      = 8'h06;
  localparam logic [7:0] RSP_NAK      = 8'h15;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/byte_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// pulses expired on the TIMEOUT_CYCLES-th one.
module byte_timer #(
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // A clear in the same cycle always wins, so a byte arriving on the last
  // allowed cycle still counts as on time.
  assign expired = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable)
      cnt_q <= '0;
    else if (!expired)
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames 5-byte debug packets from the UART RX stream, performs probe
// register reads/writes and returns ACK/NAK/read data. Optional inter-byte
// timeout is compiled in with CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser
  import uart_dbg_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         NUM_REGS       = 16,
  parameter int         TIMEOUT_CYCLES = 1200000
) (
  input  logic       iCE_CLK,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam logic [8:0] NUM_REGS_L = 9'(NUM_REGS);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, addr_q, data_q, rdata_q, err_q;
  logic       pkt_ok_q, pkt_rd_q;
  logic       timeout_hit;
  logic       csum_ok, cmd_ok, addr_ok;

  assign csum_ok = (rx_byte == (cmd_q ^ addr_q ^ data_q));
  assign cmd_ok  = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);
  assign addr_ok = ({1'b0, addr_q} < NUM_REGS_L);

`ifdef CMD_PARSER_TIMEOUT_EN
  logic in_get;
  assign in_get = (state_q == ST_GET_CMD) || (state_q == ST_GET_ADDR) ||
                  (state_q == ST_GET_DATA) || (state_q == ST_GET_CSUM);

  byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_byte_timer (
    .clk     (iCE_CLK),
    .rst     (rst),
    .clear   (rx_valid || !in_get),
    .enable  (in_get),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge iCE_CLK) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
      pkt_ok_q <= 1'b0;
      pkt_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_GET_CMD:  if (rx_valid) cmd_q  <= rx_byte;
        ST_GET_ADDR: if (rx_valid) addr_q <= rx_byte;
        ST_GET_DATA: if (rx_valid) data_q <= rx_byte;
        ST_GET_CSUM: if (rx_valid) begin
          pkt_ok_q <= csum_ok && cmd_ok && addr_ok;
          pkt_rd_q <= (cmd_q == CMD_READ);
        end
        ST_EXEC: begin
          if (pkt_ok_q && pkt_rd_q) rdata_q <= reg_rdata;
          if (!pkt_ok_q)            err_q   <= sat_inc8(err_q);
        end
        default: ;
      endcase
      // Only possible in GET_*, so never collides with the EXEC increment.
      if (timeout_hit) err_q <= sat_inc8(err_q);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (rx_valid && rx_byte == SYNC_BYTE) state_d = ST_GET_CMD;
      ST_GET_CMD:  if (rx_valid) state_d = ST_GET_ADDR;
      ST_GET_ADDR: if (rx_valid) state_d = ST_GET_DATA;
      ST_GET_DATA: if (rx_valid) state_d = ST_GET_CSUM;
      ST_GET_CSUM: if (rx_valid) state_d = ST_EXEC;
      ST_EXEC:     state_d = ST_SEND0;
      ST_SEND0:    if (tx_ready) state_d = (pkt_ok_q && pkt_rd_q) ? ST_SEND1 : ST_IDLE;
      ST_SEND1:    if (tx_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (timeout_hit) state_d = ST_IDLE;
  end

  always_comb begin
    tx_byte = 8'h00;
    unique case (state_q)
      ST_SEND0: tx_byte = pkt_ok_q ? RSP_ACK : RSP_NAK;
      ST_SEND1: tx_byte = rdata_q;
      default:  tx_byte = 8'h00;
    endcase
  end

  assign tx_valid  = (state_q == ST_SEND0) || (state_q == ST_SEND1);
  assign busy      = (state_q == ST_EXEC) || tx_valid;
  assign reg_wr_en = (state_q == ST_EXEC) && pkt_ok_q && !pkt_rd_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = data_q;
  assign err_count = err_q;

endmodule
